// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) for the single-port unified memory.
// Optional misalignment checking is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [1:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_sel,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       misaligned;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (d_sel)
      2'd1:    misaligned = d_addr[0];
      2'd2:    misaligned = |d_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Data port wins contention until fetch has been denied LIMIT times in a row.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req && d_req) begin
      if (starve_cnt >= LIMIT) i_gnt = 1'b1;
      else                     d_gnt = 1'b1;
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_sel   = 2'd2;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_sel   = d_sel;
      mem_wen   = d_wen && !misaligned;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      if (i_gnt) i_rdata <= mem_rdata;
      // Stores and rejected accesses return zero data.
      if (d_gnt) d_rdata <= (d_wen || misaligned) ? '0 : mem_rdata;
      if (i_req && !i_gnt) begin
        if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic d_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_err_q <= 1'b0;
    else        d_err_q <= d_gnt && misaligned;
  end
  assign d_err = d_err_q;
`else
  assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps, response scoreboard,
// and a behavioural model of the asynchronous-read memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wen = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [1:0]  d_sel = 2'd2;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_sel;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       i_q[$];
  resp_t       d_q[$];
  logic [31:0] i_hold = '0;
  logic [31:0] d_hold = '0;
  logic [31:0] mem_q [0:63];
  int          checks = 0;
  int          failures = 0;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_q[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wen) begin
      case (mem_sel)
        2'd0:    mem_q[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        2'd1:    mem_q[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: mem_q[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Responses appear one cycle after the grant; compare them on the falling edge.
  always @(negedge clk) begin
    resp_t r;
    if (i_q.size() > 0) begin
      r = i_q.pop_front();
      check("i_rvalid", {31'b0, i_rvalid}, {31'b0, r.valid});
      check("i_rdata", i_rdata, r.rdata);
    end else begin
      check("i_rvalid_idle", {31'b0, i_rvalid}, 32'd0);
    end
    if (d_q.size() > 0) begin
      r = d_q.pop_front();
      check("d_rvalid", {31'b0, d_rvalid}, {31'b0, r.valid});
      check("d_rdata", d_rdata, r.rdata);
      if (r.valid) check("d_err", {31'b0, d_err}, {31'b0, r.err});
    end else begin
      check("d_rvalid_idle", {31'b0, d_rvalid}, 32'd0);
    end
  end

  task automatic step(input string tag,
                      input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [1:0] ds,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input logic eig, input logic edg,
                      input logic [31:0] erd_i, input logic [31:0] erd_d, input logic eerr);
    @(negedge clk);
    i_req = ir; i_addr = ia;
    d_req = dr; d_wen = dw; d_sel = ds; d_addr = da; d_wdata = dwd;
    #1;
    check({tag, ".i_gnt"}, {31'b0, i_gnt}, {31'b0, eig});
    check({tag, ".d_gnt"}, {31'b0, d_gnt}, {31'b0, edg});
    check({tag, ".excl"}, {31'b0, i_gnt & d_gnt}, 32'd0);
    if (eig) i_hold = erd_i;
    if (edg) d_hold = erd_d;
    i_q.push_back('{valid: eig, rdata: i_hold, err: 1'b0});
    d_q.push_back('{valid: edg, rdata: d_hold, err: eerr});
  endtask

  task automatic check_mem(input string tag, input logic [31:0] a, input logic [1:0] s,
                           input logic w, input logic [31:0] wd);
    check({tag, ".mem_addr"}, mem_addr, a);
    check({tag, ".mem_sel"}, {30'b0, mem_sel}, {30'b0, s});
    check({tag, ".mem_wen"}, {31'b0, mem_wen}, {31'b0, w});
    check({tag, ".mem_wdata"}, mem_wdata, wd);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem_q[k] = '0;
    mem_q[4] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    #1;
    check("rst.i_rvalid", {31'b0, i_rvalid}, 32'd0);
    check("rst.d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rst.i_rdata", i_rdata, 32'd0);
    check("rst.d_rdata", d_rdata, 32'd0);
    check("rst.d_err", {31'b0, d_err}, 32'd0);
    check_mem("rst.idle", 32'd0, 2'd2, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only, then store/load round trip.
    step("fetch", 1, 32'h10, 0, 0, 2'd2, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
    check_mem("fetch", 32'h10, 2'd2, 1'b0, 32'd0);
    step("store", 0, 0, 1, 1, 2'd2, 32'h4, 32'hF5, 0, 1, 0, 32'h0, 0);
    check_mem("store", 32'h4, 2'd2, 1'b1, 32'hF5);
    step("load", 0, 0, 1, 0, 2'd2, 32'h4, 0, 0, 1, 0, 32'hF5, 0);
    step("idle0", 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0);

    // Continuous contention: data for four cycles, fetch on the fifth, data again.
    for (int c = 1; c <= 6; c++) begin
      step($sformatf("cont%0d", c), 1, 32'h10, 1, 0, 2'd2, 32'h4, 0,
           (c == 5), (c != 5), 32'hDEADBEEF, 32'hF5, 0);
    end
    step("idle1", 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back fetch then load.
    step("b2b_f", 1, 32'h10, 0, 0, 2'd2, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
    step("b2b_d", 0, 0, 1, 0, 2'd2, 32'h4, 0, 0, 1, 0, 32'hF5, 0);

    // Fetch loses once, then withdraws: no access issued.
    step("drop_a", 1, 32'h10, 1, 0, 2'd2, 32'h4, 0, 0, 1, 0, 32'hF5, 0);
    step("drop_b", 0, 32'h10, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0);
    check_mem("drop_b", 32'd0, 2'd2, 1'b0, 32'd0);

    // Byte store into lane 1 of word 0x20, read back as a word.
    step("sb", 0, 0, 1, 1, 2'd0, 32'h21, 32'h000000AB, 0, 1, 0, 0, 0);
    check_mem("sb", 32'h21, 2'd0, 1'b1, 32'hAB);
    step("lw20", 0, 0, 1, 0, 2'd2, 32'h20, 0, 0, 1, 0, 32'h0000AB00, 0);

    // Misaligned word store to 6: rejected with the check, written through without it.
    step("mis_st", 0, 0, 1, 1, 2'd2, 32'h6, 32'h1234, 0, 1, 0, 0, ALIGN_EN);
    check_mem("mis_st", 32'h6, 2'd2, !ALIGN_EN, 32'h1234);
    step("mis_ld", 0, 0, 1, 0, 2'd2, 32'h4, 0, 0, 1, 0, ALIGN_EN ? 32'hF5 : 32'h1234, 0);

    // Reset asserted during a fetch grant: no response, registers and counter cleared.
    step("pre_rst", 1, 32'h10, 1, 0, 2'd2, 32'h4, 0, 0, 1, 0, ALIGN_EN ? 32'hF5 : 32'h1234, 0);
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b0;
    #1;
    check("rstmid.i_gnt", {31'b0, i_gnt}, 32'd1);
    check("rstmid.cnt_pre", {28'b0, dut.starve_cnt}, 32'd1);
    i_hold = '0;
    d_hold = '0;
    i_q.push_back('{valid: 1'b0, rdata: 32'd0, err: 1'b0});
    d_q.push_back('{valid: 1'b0, rdata: 32'd0, err: 1'b0});
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.d_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rstmid.d_rdata", d_rdata, 32'd0);
    check("rstmid.cnt", {28'b0, dut.starve_cnt}, 32'd0);
    @(negedge clk);
    i_req = 1'b0;
    rst_n = 1'b1;

    step("post_rst", 1, 32'h10, 0, 0, 2'd2, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0);
    step("drain0", 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0);
    step("drain1", 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port unified `mem` between the instruction-fetch stage and the load/store stage of the core. Grants at most one access per cycle, drives `mem`'s address/size/write-enable/write-data inputs, and returns registered read data to the winning requester one cycle later. Fixed data-port priority, with a starvation counter that guarantees forward progress for fetch.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied fetch cycles after which fetch takes priority; legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `i_req`  in  1  fetch request; `i_addr` held stable until granted
- `i_addr`  in  32  fetch byte address (word access)
- `i_gnt`  out  1  fetch granted this cycle (combinational)
- `i_rvalid`  out  1  fetch read data valid (registered)
- `i_rdata`  out  32  fetch read data
- `d_req`  in  1  data request; all `d_*` inputs held stable until granted
- `d_wen`  in  1  1 = store, 0 = load
- `d_sel`  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_gnt`  out  1  data granted this cycle (combinational)
- `d_rvalid`  out  1  data response valid (registered)
- `d_rdata`  out  32  load data
- `d_err`  out  1  access error; valid with `d_rvalid`
- `mem_addr`  out  32  to `mem.addr`
- `mem_sel`  out  2  to `mem.sel`
- `mem_wen`  out  1  to `mem.wen`
- `mem_wdata`  out  32  to `mem.data_i`
- `mem_rdata`  in  32  from `mem.data_o` (asynchronous read)

## Operation
- Grant decision per cycle, combinational from requests and `starve_cnt`:
  - only one `*_req` high → that requester granted
  - both high, `starve_cnt < STARVE_LIMIT` → data granted
  - both high, `starve_cnt == STARVE_LIMIT` → fetch granted
  - neither high → no grant
- `i_gnt` and `d_gnt` are never high together.
- Memory drive: fetch grant → `mem_addr=i_addr`, `mem_sel=2`, `mem_wen=0`; data grant → `d_addr`, `d_sel`, `mem_wen=d_wen`, `mem_wdata=d_wdata`; idle → `mem_addr=0`, `mem_sel=2`, `mem_wen=0`, `mem_wdata=0`.
- `starve_cnt` (4-bit register): +1 saturating at `STARVE_LIMIT` when `i_req && !i_gnt`; cleared to 0 when `i_gnt` or `!i_req`.
- Responses: fetch grant → next cycle `i_rvalid=1`, `i_rdata=mem_rdata` sampled in the grant cycle. Data grant → next cycle `d_rvalid=1` for loads and stores; `d_rdata=mem_rdata` for loads, 0 for stores. `d_err=0` unless set by the configuration feature.
- `*_rdata` hold their last value when `*_rvalid=0`.

## Timing
- Grant: 0-cycle (same cycle as request when winning). Response: exactly 1 cycle after grant; back-to-back grants yield back-to-back `rvalid`.
- Store commits at the rising edge ending the grant cycle (`mem` write timing).
- Reset (`rst_n=0`, asynchronous): `i_rvalid=0`, `d_rvalid=0`, `i_rdata=0`, `d_rdata=0`, `d_err=0`, `starve_cnt=0`. Combinational outputs follow requests; with both requests low they are idle values. A grant issued in the cycle reset asserts produces no response.
- Requester dropping `*_req` before grant: permitted; no access issued.
- Worst-case fetch wait under continuous data requests: `STARVE_LIMIT` cycles; fetch wins on cycle `STARVE_LIMIT+1`.

## Configuration
- `MEM_ARB_ALIGN_CHECK_EN` defined: data access is misaligned if `d_sel=1 && d_addr[0]`, `d_sel=2 && d_addr[1:0]!=0`, or `d_sel=3`. Misaligned access is still granted (handshake completes) but `mem_wen` forced 0; next cycle `d_rvalid=1`, `d_err=1`, `d_rdata=0`.
- Undefined: `d_err` tied 0; all accesses passed to `mem` unchanged.

## Test plan
- Reset then fetch only: `i_req=1`, `i_addr=0x10`, mem word 0x10 = 0xDEADBEEF → `i_gnt=1` same cycle, next cycle `i_rvalid=1`, `i_rdata=0xDEADBEEF`.
- Store then load: `d_wen=1`, `d_sel=2`, `d_addr=4`, `d_wdata=0xF5` → `d_rvalid=1`, `d_rdata=0`; then load addr 4 → `d_rdata=0x000000F5`.
- Contention, `STARVE_LIMIT=4`: both requests held high continuously → `d_gnt` cycles 1–4, `i_gnt` cycle 5, `starve_cnt` returns to 0, `d_gnt` cycle 6.
- Back-to-back: fetch cycle 0, load cycle 1 → `i_rvalid` cycle 1, `d_rvalid` cycle 2, never both grants high.
- Reset mid-operation: assert `rst_n=0` in a grant cycle → no `rvalid` next cycle, all registered outputs 0, counter 0.
- With `MEM_ARB_ALIGN_CHECK_EN`: store `d_sel=2`, `d_addr=6` → `mem_wen=0`, next cycle `d_err=1`; memory at 4 unchanged. Without macro: same stimulus → `mem_wen=1`, `d_err=0`.
